// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, polarity normalisation and a
// per-button debounce FSM producing a clean level, press/release/long events and a toggle bit.
module btn_conditioner #(
  parameter int F_CLK_HZ       = 25_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int ACTIVE_LOW_BTN = 1,
  parameter int N_BTN          = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] toggle
);

  localparam int DB_TICKS   = (F_CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int LONG_TICKS = (F_CLK_HZ / 1000) * LONG_MS;
  localparam int DW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam int LW = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_TICKS - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);
  localparam logic [N_BTN-1:0] IDLE_LVL = (ACTIVE_LOW_BTN != 0) ? '1 : '0;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  logic [N_BTN-1:0] sync_1_reg;
  logic [N_BTN-1:0] sync_2_reg;
  logic [N_BTN-1:0] act;

  // Synchroniser resets to the released pad level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1_reg <= IDLE_LVL;
      sync_2_reg <= IDLE_LVL;
    end else begin
      sync_1_reg <= btn_raw;
      sync_2_reg <= sync_1_reg;
    end
  end

  assign act = (ACTIVE_LOW_BTN != 0) ? ~sync_2_reg : sync_2_reg;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    state_t        state_reg;
    logic [DW-1:0] dcnt_reg;
    logic [LW-1:0] lcnt_reg;
    logic          long_done_reg;
    logic          pressed_reg;
    logic          press_reg;
    logic          release_reg;
    logic          long_reg;
    logic          toggle_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg     <= IDLE;
        dcnt_reg      <= '0;
        lcnt_reg      <= '0;
        long_done_reg <= 1'b0;
        pressed_reg   <= 1'b0;
        press_reg     <= 1'b0;
        release_reg   <= 1'b0;
        long_reg      <= 1'b0;
        toggle_reg    <= 1'b0;
      end else begin
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
        long_reg    <= 1'b0;
        case (state_reg)
          IDLE: begin
            if (act[gi]) begin
              state_reg <= PRESS_CHK;
              dcnt_reg  <= '0;
            end
          end
          PRESS_CHK: begin
            if (!act[gi]) begin
              state_reg <= IDLE;
            end else if (dcnt_reg == DB_LAST) begin
              state_reg     <= HELD;
              pressed_reg   <= 1'b1;
              press_reg     <= 1'b1;
              toggle_reg    <= ~toggle_reg;
              lcnt_reg      <= '0;
              long_done_reg <= 1'b0;
            end else begin
              dcnt_reg <= dcnt_reg + 1'b1;
            end
          end
          HELD: begin
            if (!act[gi]) begin
              state_reg <= REL_CHK;
              dcnt_reg  <= '0;
            end else if (lcnt_reg == LONG_LAST && !long_done_reg) begin
              long_reg      <= 1'b1;
              long_done_reg <= 1'b1;
            end else if (lcnt_reg < LONG_LAST) begin
              lcnt_reg <= lcnt_reg + 1'b1;
            end
          end
          REL_CHK: begin
            // A bounce back to active resumes the hold; the long counter is frozen meanwhile.
            if (act[gi]) begin
              state_reg <= HELD;
            end else if (dcnt_reg == DB_LAST) begin
              state_reg   <= IDLE;
              pressed_reg <= 1'b0;
              release_reg <= 1'b1;
            end else begin
              dcnt_reg <= dcnt_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end

    assign pressed[gi]       = pressed_reg;
    assign press_pulse[gi]   = press_reg;
    assign release_pulse[gi] = release_reg;
    assign long_pulse[gi]    = long_reg;
    assign toggle[gi]        = toggle_reg;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: directed scenarios plus random bouncing input,
// checked every cycle against a run-length reference model of the debounce rules.
module tb_btn_conditioner;
  localparam int DB = 4;
  localparam int LT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn_raw = 3'b111;
  logic [2:0] pressed, press_pulse, release_pulse, long_pulse, toggle;

  btn_conditioner #(
    .F_CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(10), .ACTIVE_LOW_BTN(1), .N_BTN(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .toggle(toggle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [14:0] exp_q[$];

  // Event log filled by the monitor from observed DUT outputs.
  int press_n[3], rel_n[3], long_n[3];
  int press_cyc[3], rel_cyc[3], long_cyc[3];
  int all_press_n = 0;

  // Reference model state: delayed pad samples and per-button run lengths.
  logic [2:0] m_h1, m_h2, m_level, m_tog;
  int m_run[3], m_hcnt[3];

  task automatic model_step(input logic r, input logic [2:0] raw, output logic [14:0] e);
    logic [2:0] pp, rp, lp, a;
    pp = '0; rp = '0; lp = '0;
    if (r) begin
      m_h1 = 3'b111; m_h2 = 3'b111; m_level = '0; m_tog = '0;
      for (int i = 0; i < 3; i++) begin m_run[i] = 0; m_hcnt[i] = 0; end
    end else begin
      a = ~m_h2;
      m_h2 = m_h1;
      m_h1 = raw;
      for (int i = 0; i < 3; i++) begin
        if (a[i] == m_level[i]) begin
          // Only uninterrupted held cycles count toward the long press.
          if (m_level[i] && m_run[i] == 0 && m_hcnt[i] < LT) begin
            m_hcnt[i]++;
            if (m_hcnt[i] == LT) lp[i] = 1'b1;
          end
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_run[i] = 0;
            m_level[i] = ~m_level[i];
            if (m_level[i]) begin
              pp[i] = 1'b1; m_tog[i] = ~m_tog[i]; m_hcnt[i] = 0;
            end else begin
              rp[i] = 1'b1;
            end
          end
        end
      end
    end
    e = {m_level, pp, rp, lp, m_tog};
  endtask

  task automatic step(input logic r, input logic [2:0] raw);
    logic [14:0] e;
    @(negedge clk);
    rst = r;
    btn_raw = raw;
    model_step(r, raw, e);
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic r, input logic [2:0] raw, input int n);
    for (int k = 0; k < n; k++) step(r, raw);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int total_events();
    int s = 0;
    for (int i = 0; i < 3; i++) s += press_n[i] + rel_n[i] + long_n[i];
    return s;
  endfunction

  // Monitor: one comparison per clock against the queued expectation.
  initial begin
    logic [14:0] e, got;
    for (int i = 0; i < 3; i++) begin
      press_n[i] = 0; rel_n[i] = 0; long_n[i] = 0;
      press_cyc[i] = 0; rel_cyc[i] = 0; long_cyc[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {pressed, press_pulse, release_pulse, long_pulse, toggle};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs cyc %0d got prs=%b pp=%b rp=%b lp=%b tg=%b want prs=%b pp=%b rp=%b lp=%b tg=%b",
                   cyc, got[14:12], got[11:9], got[8:6], got[5:3], got[2:0],
                   e[14:12], e[11:9], e[8:6], e[5:3], e[2:0]);
        end
        if (got[11:3] != 0)
          $display("cyc %0d events press=%b release=%b long=%b pressed=%b toggle=%b",
                   cyc, got[11:9], got[8:6], got[5:3], got[14:12], got[2:0]);
      end
      for (int i = 0; i < 3; i++) begin
        if (press_pulse[i] === 1'b1) begin press_n[i]++; press_cyc[i] = cyc; end
        if (release_pulse[i] === 1'b1) begin rel_n[i]++; rel_cyc[i] = cyc; end
        if (long_pulse[i] === 1'b1) begin long_n[i]++; long_cyc[i] = cyc; end
      end
      if (press_pulse === 3'b111) all_press_n++;
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog cyc %0d want completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stimulus
  initial begin
    int t0, snap, r0, p0, rem[3];
    logic [2:0] lvl;

    hold(1'b1, 3'b111, 3);
    chk("reset_outs", int'({pressed, press_pulse, release_pulse, long_pulse, toggle}), 0);

    snap = total_events();
    hold(1'b0, 3'b111, 50);
    chk("idle_no_pulses", total_events() - snap, 0);

    // Single press and release of button 0
    step(1'b0, 3'b110); t0 = cyc;
    hold(1'b0, 3'b110, 19);
    chk("press_latency", press_cyc[0] - t0, 7);
    chk("press_count", press_n[0], 1);
    chk("pressed0_held", int'(pressed[0]), 1);
    chk("toggle0_set", int'(toggle[0]), 1);
    step(1'b0, 3'b111); t0 = cyc;
    hold(1'b0, 3'b111, 11);
    chk("release_latency", rel_cyc[0] - t0, 7);
    chk("pressed0_clear", int'(pressed[0]), 0);

    // Bouncing input on button 1
    snap = total_events();
    hold(1'b0, 3'b101, 3); hold(1'b0, 3'b111, 1);
    hold(1'b0, 3'b101, 2); hold(1'b0, 3'b111, 10);
    chk("bounce_no_events", total_events() - snap, 0);
    chk("bounce_pressed1", int'(pressed[1]), 0);
    r0 = rel_n[1];
    hold(1'b0, 3'b101, 12); hold(1'b0, 3'b111, 2); hold(1'b0, 3'b101, 8);
    chk("held_glitch_norel", rel_n[1] - r0, 0);
    chk("held_glitch_pressed", int'(pressed[1]), 1);
    hold(1'b0, 3'b111, 12);
    chk("held_glitch_rel", rel_n[1] - r0, 1);

    // Long press on button 2
    p0 = long_n[2]; r0 = rel_n[2];
    hold(1'b0, 3'b011, 30);
    chk("long_once", long_n[2] - p0, 1);
    chk("long_offset", long_cyc[2] - press_cyc[2], LT);
    hold(1'b0, 3'b111, 15);
    chk("long_after_rel", long_n[2] - p0, 1);
    chk("long_rel", rel_n[2] - r0, 1);

    // Simultaneous presses, then a second press of button 0
    hold(1'b1, 3'b111, 2);
    snap = all_press_n;
    hold(1'b0, 3'b000, 12); hold(1'b0, 3'b111, 12);
    chk("all_press_same_cycle", all_press_n - snap, 1);
    hold(1'b0, 3'b110, 12); hold(1'b0, 3'b111, 12);
    chk("toggle_pattern", int'(toggle), 6);

    // Reset while button 0 is held
    hold(1'b0, 3'b110, 20);
    r0 = rel_n[0]; p0 = press_n[0];
    step(1'b1, 3'b110);
    step(1'b0, 3'b110); t0 = cyc;
    chk("midrst_outs", int'({pressed, press_pulse, release_pulse, long_pulse, toggle}), 0);
    hold(1'b0, 3'b110, 11);
    chk("midrst_no_release", rel_n[0] - r0, 0);
    chk("midrst_redetect", press_cyc[0] - t0, 7);
    chk("midrst_press_count", press_n[0] - p0, 1);
    hold(1'b0, 3'b111, 12);

    // Random bouncing on all buttons with occasional resets
    lvl = 3'b111;
    for (int i = 0; i < 3; i++) rem[i] = $urandom_range(1, 20);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          lvl[i] = ~lvl[i];
          rem[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 25);
        end
      end
      step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0, lvl);
    end
    hold(1'b0, 3'b111, 12);

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-side counterpart of the blink/button top level, which currently wires raw pad levels straight to outputs.
- Conditions N_BTN mechanical push buttons: synchronises each one, normalises polarity, debounces it, and emits a clean level plus single-cycle press, release and long-press events and a per-button toggle bit.
- Sits between the button pads and any logic consuming button state (q-lane drivers, mode selectors).

Parameters:
- F_CLK_HZ, 25_000_000, clock frequency in Hz.
- DEBOUNCE_MS, 20, time the input must stay stable before a change is accepted. DB_TICKS = (F_CLK_HZ/1000)*DEBOUNCE_MS, must be ≥1.
- LONG_MS, 1000, hold time for the long-press event. LONG_TICKS = (F_CLK_HZ/1000)*LONG_MS, must be ≥1.
- ACTIVE_LOW_BTN, 1, 1 means a pressed button reads 0 on the pad; 0 means a pressed button reads 1.
- N_BTN, 3, number of independent buttons.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_raw  input  N_BTN  asynchronous pad levels.
- pressed  output  N_BTN  debounced level; 1 = held.
- press_pulse  output  N_BTN  1-cycle strobe on accepted press.
- release_pulse  output  N_BTN  1-cycle strobe on accepted release.
- long_pulse  output  N_BTN  1-cycle strobe once per press after LONG_TICKS held.
- toggle  output  N_BTN  flips on every accepted press.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high):
  - Both synchroniser stages load the inactive pad level (ACTIVE_LOW_BTN ? 1 : 0).
  - Every FSM goes to IDLE; all counters and the long_done flag clear.
  - pressed, press_pulse, release_pulse, long_pulse and toggle all reset to 0.
- Synchroniser: 2 flip-flops per bit. After it, act = ACTIVE_LOW_BTN ? ~sync : sync.
- Per-button FSM: one per bit, fully independent. Each has its own debounce counter dcnt and long counter lcnt.
  - IDLE (pressed=0):
    - act=1 → PRESS_CHK, dcnt=0.
  - PRESS_CHK:
    - act=0 → IDLE; no event.
    - Else, if dcnt==DB_TICKS-1 → HELD: pressed=1, press_pulse=1 for one cycle, toggle flips, lcnt=0, long_done=0.
    - Else dcnt++.
  - HELD (pressed=1):
    - act=0 → REL_CHK, dcnt=0.
    - Else, if lcnt==LONG_TICKS-1 and !long_done → long_pulse=1 for one cycle, long_done=1.
    - Else, if lcnt<LONG_TICKS-1 → lcnt++ (lcnt saturates).
  - REL_CHK (pressed stays 1):
    - act=1 → HELD; lcnt holds (does not advance during REL_CHK); long_done is kept.
    - Else, if dcnt==DB_TICKS-1 → IDLE: pressed=0, release_pulse=1 for one cycle.
    - Else dcnt++.
- Latency:
  - press_pulse and pressed rise after clock edge DB_TICKS+2, counting edge 0 as the first edge that samples btn_raw pressed (input held stable).
  - release_pulse follows the same rule on release.
  - long_pulse is asserted exactly LONG_TICKS cycles after the press_pulse cycle.
- Bounce rejection:
  - Any act change shorter than DB_TICKS cycles produces no event and no change to pressed.
  - A glitch during PRESS_CHK restarts debounce from IDLE.
  - A glitch during REL_CHK returns to HELD with no release.
- Event ordering:
  - At most one of press_pulse, release_pulse, long_pulse is high per button per cycle.
  - long_pulse fires at most once per press, and never after the release is accepted.
- Reset mid-operation:
  - Immediate return to IDLE with no release_pulse; toggle clears.
  - A button still held after reset is re-detected as a fresh press after the full debounce latency.
- Simultaneous activity on several buttons: fully independent; events for different bits may coincide in the same cycle.
- Counter widths: $clog2 of the tick count, minimum 1 bit. No wrap-around is reachable.

Test Plan:
All tests use F_CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=10 (DB_TICKS=4, LONG_TICKS=10), ACTIVE_LOW_BTN=1, N_BTN=3.
1. Reset → all outputs 0. btn_raw=3'b111 held 50 cycles → no pulses.
2. btn_raw[0]=0 from edge 0, held → press_pulse[0] high only in the cycle after edge 6; pressed[0]=1 and toggle[0]=1 from then on. Release held → release_pulse[0] after 6 edges; pressed[0]=0.
3. Bounce: btn_raw[1] low 3 cycles, high 1, low 2, then high → no pulses on any output, pressed[1]=0. During HELD, a 2-cycle high glitch → no release_pulse.
4. btn_raw[2] held low 30 cycles → exactly one long_pulse[2], 10 cycles after press_pulse[2]. Release → release_pulse[2]; no second long_pulse.
5. All three buttons pressed on the same edge → press_pulse=3'b111 in one cycle. A second press of button 0 → toggle=3'b110.
6. Button 0 held, rst asserted 1 cycle during HELD → outputs 0 the next cycle with no release_pulse. Press re-detected 6 edges after reset deasserts.
